// File: rtl/fp16_mul_stream_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | fp16_mul_stream_ctrl                                                      |
// | Valid/ready front end, in-flight tracking and classified result FIFO for |
// | a fixed-latency, non-stalling FP16 multiplier.                            |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module fp16_mul_stream_ctrl #(
    parameter int MUL_LATENCY = 11,
    parameter int FIFO_DEPTH  = 16,
    localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_a,
    input  logic [15:0]   in_b,
    output logic [15:0]   mul_a,
    output logic [15:0]   mul_b,
    input  logic [15:0]   mul_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [15:0]   out_result,
    output logic [3:0]    out_flags,
    output logic [CW-1:0] inflight,
    output logic [CW-1:0] fifo_count,
    output logic          err_overflow
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] C_DEPTH = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    logic [MUL_LATENCY-1:0] vld_sr_q, vld_sr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          inflight_q, inflight_d;
    logic [CW-1:0]          fifo_count_q, fifo_count_d;
    logic                   err_overflow_q, err_overflow_d;
    logic [19:0]            mem_q [FIFO_DEPTH];

    logic                   w_issue;
    logic                   w_retire;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_wr_en;
    logic [CW:0]            w_credit;
    logic [4:0]             w_exp;
    logic [9:0]             w_frac;
    logic [3:0]             w_cap_flags;

    // Credit covers both queued results and results still inside the multiplier.
    assign w_credit  = {1'b0, fifo_count_q} + {1'b0, inflight_q};
    assign in_ready  = (w_credit < {1'b0, C_DEPTH});
    assign w_issue   = in_valid & in_ready;
    assign w_retire  = vld_sr_q[MUL_LATENCY-1];
    assign out_valid = (fifo_count_q != '0);
    assign w_pop     = out_valid & out_ready;
    assign w_full    = (fifo_count_q == C_DEPTH);
    assign w_wr_en   = w_retire & (~w_full | w_pop);

    assign mul_a = w_issue ? in_a : 16'h0000;
    assign mul_b = w_issue ? in_b : 16'h0000;

    assign w_exp       = mul_out[14:10];
    assign w_frac      = mul_out[9:0];
    assign w_cap_flags = {(w_exp == 5'h1f) && (w_frac != 10'd0),
                          (w_exp == 5'h1f) && (w_frac == 10'd0),
                          (w_exp == 5'h00) && (w_frac == 10'd0),
                          (w_exp == 5'h00) && (w_frac != 10'd0)};

    assign out_result   = mem_q[rd_ptr_q][15:0];
    assign out_flags    = mem_q[rd_ptr_q][19:16];
    assign inflight     = inflight_q;
    assign fifo_count   = fifo_count_q;
    assign err_overflow = err_overflow_q;

    always_comb begin
        vld_sr_d    = '0;
        vld_sr_d[0] = w_issue;
        for (int k = 1; k < MUL_LATENCY; k++) begin
            vld_sr_d[k] = vld_sr_q[k-1];
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({w_issue, w_retire})
            2'b10:   inflight_d = inflight_q + C_ONE;
            2'b01:   inflight_d = inflight_q - C_ONE;
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        fifo_count_d = fifo_count_q;
        case ({w_wr_en, w_pop})
            2'b10:   fifo_count_d = fifo_count_q + C_ONE;
            2'b01:   fifo_count_d = fifo_count_q - C_ONE;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    always_comb begin
        wr_ptr_d       = w_wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d       = w_pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        err_overflow_d = err_overflow_q | (w_retire & w_full & ~w_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_sr_q       <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            inflight_q     <= '0;
            fifo_count_q   <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            vld_sr_q       <= vld_sr_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            inflight_q     <= inflight_d;
            fifo_count_q   <= fifo_count_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    // Storage needs no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_en) begin
            mem_q[wr_ptr_q] <= {w_cap_flags, mul_out};
        end
    end

endmodule
`default_nettype wire
